rect_filler: RTL and testbench

//  Parametrised raster fill engine. Successor to the full-screen clear. Streams every pixel of an

---
 rtl/lab6_gfx_pkg.sv | 11 +
 rtl/raster_counter.sv | 41 ++++
 rtl/rect_filler.sv | 107 ++++++++++
 tb/tb_rect_filler.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/lab6_gfx_pkg.sv
// lab6_gfx_pkg: shared graphics defaults, pixel types and fill FSM state encoding.
package lab6_gfx_pkg;
    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;
    localparam int DEF_COORD_W  = 11;
    localparam int DEF_COLOR_W  = 1;
    localparam int DEF_CNT_W    = 20;
    typedef logic [DEF_COORD_W-1:0] coord_t;
    typedef logic [DEF_COLOR_W-1:0] color_t;
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL, S_DONE} fill_state_t;
endpackage

// File: rtl/raster_counter.sv
// raster_counter: 2-D x-first stepper over [xa..xb] x [ya..yb]; never steps past (xb,yb) when driven correctly.
module raster_counter #(
    parameter int COORD_W = 11
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [COORD_W-1:0] i_xa,
    input  logic [COORD_W-1:0] i_ya,
    input  logic [COORD_W-1:0] i_xb,
    input  logic [COORD_W-1:0] i_yb,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_last
);
    logic [COORD_W-1:0] r_x, r_y, r_xa, r_xb, r_yb;
    logic               w_eol;
    assign w_eol = (r_x == r_xb);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_x  <= '0;
            r_y  <= '0;
            r_xa <= '0;
            r_xb <= '0;
            r_yb <= '0;
        end else if (i_load) begin
            r_x  <= i_xa;
            r_y  <= i_ya;
            r_xa <= i_xa;
            r_xb <= i_xb;
            r_yb <= i_yb;
        end else if (i_step) begin
            r_x <= w_eol ? r_xa : r_x + COORD_W'(1);
            r_y <= w_eol ? r_y + COORD_W'(1) : r_y;
        end
    end
    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = w_eol && (r_y == r_yb);
endmodule

// File: rtl/rect_filler.sv
// rect_filler: streams every pixel of a normalised, screen-clipped rectangle in one colour
// to a valid/ready frame-buffer port, with abort and transferred-pixel count.
module rect_filler
    import lab6_gfx_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int COORD_W  = DEF_COORD_W,
    parameter int COLOR_W  = DEF_COLOR_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COLOR_W-1:0] color,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   pix_count
);
    localparam logic [COORD_W-1:0] XMAX = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] YMAX = COORD_W'(SCREEN_H - 1);
    fill_state_t        r_state, w_next;
    logic [COORD_W-1:0] r_x0, r_y0, r_x1, r_y1;
    logic [COLOR_W-1:0] r_color;
    logic               r_valid, r_busy, r_done;
    logic [CNT_W-1:0]   r_count;
    logic [COORD_W-1:0] w_xa, w_xm, w_xb, w_ya, w_ym, w_yb;
    logic               w_empty, w_xfer, w_last, w_load, w_step;
    assign w_xa    = (r_x0 < r_x1) ? r_x0 : r_x1;
    assign w_xm    = (r_x0 < r_x1) ? r_x1 : r_x0;
    assign w_xb    = (w_xm > XMAX) ? XMAX : w_xm;
    assign w_ya    = (r_y0 < r_y1) ? r_y0 : r_y1;
    assign w_ym    = (r_y0 < r_y1) ? r_y1 : r_y0;
    assign w_yb    = (w_ym > YMAX) ? YMAX : w_ym;
    assign w_empty = (w_xa > XMAX) || (w_ya > YMAX);
    assign w_xfer  = r_valid && pix_ready;
    // The last pixel is never stepped past, so the counter stays inside the clipped box.
    assign w_load  = (r_state == S_SETUP) && !abort && !w_empty;
    assign w_step  = (r_state == S_FILL) && !abort && w_xfer && !w_last;
    raster_counter #(.COORD_W(COORD_W)) u_cnt (
        .clock  (clock),
        .reset_n(reset_n),
        .i_load (w_load),
        .i_step (w_step),
        .i_xa   (w_xa),
        .i_ya   (w_ya),
        .i_xb   (w_xb),
        .i_yb   (w_yb),
        .o_x    (x),
        .o_y    (y),
        .o_last (w_last)
    );
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_SETUP : S_IDLE;
            S_SETUP: w_next = abort ? S_IDLE : (w_empty ? S_DONE : S_FILL);
            S_FILL:  w_next = abort ? S_IDLE : ((w_xfer && w_last) ? S_DONE : S_FILL);
            S_DONE:  w_next = start ? S_DONE : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
            r_x0    <= '0;
            r_y0    <= '0;
            r_x1    <= '0;
            r_y1    <= '0;
            r_color <= '0;
        end else begin
            r_state <= w_next;
            r_valid <= (w_next == S_FILL);
            r_busy  <= (w_next == S_SETUP) || (w_next == S_FILL);
            r_done  <= (w_next == S_DONE);
            if (r_state == S_IDLE && start) begin
                r_x0    <= x0;
                r_y0    <= y0;
                r_x1    <= x1;
                r_y1    <= y1;
                r_color <= color;
                r_count <= '0;
            end else if (r_state == S_FILL && w_xfer && !abort) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end
    assign pix_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pix_count = r_count;
    assign pix_color = r_color;
endmodule

// File: tb/tb_rect_filler.sv
// tb_rect_filler: randomized and directed fills checked against a pixel-list model of the clipped rectangle.
// A reduced 64x48 screen keeps the full-screen fill short.
module tb_rect_filler;
    localparam int SW = 64;
    localparam int SH = 48;
    localparam int CW = 11;
    localparam int KW = 1;
    localparam int NW = 20;
    logic          clk = 1'b0;
    logic          rst_n, start, abort, pix_ready, pix_valid, busy, done;
    logic [CW-1:0] x0, y0, x1, y1, x, y;
    logic [KW-1:0] color, pix_color;
    logic [NW-1:0] pix_count;
    int            total = 0;
    int            bad = 0;
    int            qx[$];
    int            qy[$];
    int            pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    always #5 clk = ~clk;
    rect_filler #(.SCREEN_W(SW), .SCREEN_H(SH), .COORD_W(CW), .COLOR_W(KW), .CNT_W(NW)) dut (
        .clock    (clk),
        .reset_n  (rst_n),
        .start    (start),
        .abort    (abort),
        .x0       (x0),
        .y0       (y0),
        .x1       (x1),
        .y1       (y1),
        .color    (color),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .x        (x),
        .y        (y),
        .pix_color(pix_color),
        .busy     (busy),
        .done     (done),
        .pix_count(pix_count)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    // mode 0: ready always 1; mode 1: random ready; mode 2: fixed pattern then 1
    task automatic run(input int ax0, input int ay0, input int ax1, input int ay1, input int col,
                       input int mode, input int abort_after, input string tag);
        int xa, xb, ya, yb, cnt, n, edges, pi, px, py;
        bit pv, pr, seen, fin;
        xa = (ax0 < ax1) ? ax0 : ax1;
        xb = (ax0 < ax1) ? ax1 : ax0;
        ya = (ay0 < ay1) ? ay0 : ay1;
        yb = (ay0 < ay1) ? ay1 : ay0;
        if (xb > SW - 1) xb = SW - 1;
        if (yb > SH - 1) yb = SH - 1;
        qx.delete();
        qy.delete();
        if (xa <= SW - 1 && ya <= SH - 1)
            for (int yy = ya; yy <= yb; yy++)
                for (int xx = xa; xx <= xb; xx++) begin
                    qx.push_back(xx);
                    qy.push_back(yy);
                end
        cnt = qx.size();
        @(negedge clk);
        x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
        color = KW'(col); start = 1'b1; pix_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        x0 = CW'($urandom); y0 = CW'($urandom); x1 = CW'($urandom); y1 = CW'($urandom);
        color = ~color;
        chk({tag, "_setup_busy"}, 32'(busy), 1);
        chk({tag, "_setup_valid"}, 32'(pix_valid), 0);
        chk({tag, "_setup_count"}, 32'(pix_count), 0);
        n = 0; edges = 0; pi = 0; pv = 0; pr = 0; px = 0; py = 0; seen = 0; fin = 0;
        for (int c = 0; c < 8 * cnt + 40 && !fin; c++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done) fin = 1;
            else if (pix_valid) begin
                seen = 1;
                if (pv && !pr) begin
                    chk({tag, "_hold_x"}, 32'(x), 32'(px));
                    chk({tag, "_hold_y"}, 32'(y), 32'(py));
                end
                chk({tag, "_x"}, 32'(x), (n < cnt) ? 32'(qx[n]) : 32'hFFFF_FFFF);
                chk({tag, "_y"}, 32'(y), (n < cnt) ? 32'(qy[n]) : 32'hFFFF_FFFF);
                chk({tag, "_color"}, 32'(pix_color), 32'(col));
                if (abort_after >= 0 && n == abort_after) begin
                    abort = 1'b1; start = 1'b0; pix_ready = 1'b0; fin = 1;
                end else begin
                    pix_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 3) != 0) :
                                (pi < 7) ? pat[pi][0] : 1'b1;
                    pi++;
                    if (pix_ready) n++;
                end
                pv = 1; pr = pix_ready; px = int'(x); py = int'(y);
            end else pv = 0;
        end
        if (abort_after >= 0) begin
            @(posedge clk);
            @(negedge clk);
            abort = 1'b0;
            chk({tag, "_ab_busy"}, 32'(busy), 0);
            chk({tag, "_ab_valid"}, 32'(pix_valid), 0);
            chk({tag, "_ab_done"}, 32'(done), 0);
            chk({tag, "_ab_count"}, 32'(pix_count), 32'(abort_after));
            repeat (3) @(negedge clk);
            chk({tag, "_ab_done_later"}, 32'(done), 0);
            return;
        end
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_transfers"}, 32'(n), 32'(cnt));
        chk({tag, "_count"}, 32'(pix_count), 32'(cnt));
        chk({tag, "_end_valid"}, 32'(pix_valid), 0);
        chk({tag, "_end_busy"}, 32'(busy), 0);
        chk({tag, "_any_valid"}, 32'(seen), 32'(cnt > 0));
        if (mode == 0) chk({tag, "_latency"}, 32'(edges + 1), 32'(2 + cnt));
        repeat (3) begin
            @(negedge clk);
            chk({tag, "_hold_done"}, 32'(done), 1);
            chk({tag, "_no_retrig"}, 32'(busy), 0);
        end
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_idle_done"}, 32'(done), 0);
        chk({tag, "_idle_busy"}, 32'(busy), 0);
    endtask
    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pix_ready = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(pix_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_color", 32'(pix_color), 0);
        chk("rst_count", 32'(pix_count), 0);
        rst_n = 1'b1;
        run(0, 0, SW - 1, SH - 1, 1, 0, -1, "full");
        run(5, 3, 2, 1, 1, 1, -1, "swap");
        run(2, 1, 5, 3, 0, 0, -1, "swap_ref");
        run(SW - 10, SH - 10, SW + 60, SH + 20, 1, 0, -1, "clip");
        run(SW + 60, 10, SW + 160, 20, 1, 0, -1, "empty");
        run(0, 0, 3, 0, 1, 2, -1, "bp");
        run(0, 0, 9, 9, 1, 0, 5, "abort");
        run(1, 1, 2, 2, 1, 1, -1, "post_abort");
        run(7, 7, 7, 7, 1, 0, -1, "single");
        for (int i = 0; i < 6; i++)
            run($urandom_range(0, SW + 20), $urandom_range(0, SH + 20), $urandom_range(0, SW + 20),
                $urandom_range(0, SH + 20), $urandom_range(0, 1), 1, -1, "rnd");
        @(negedge clk);
        x0 = '0; y0 = '0; x1 = CW'(20); y1 = CW'(20); color = 1'b1; start = 1'b1; pix_ready = 1'b1;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk("arst_valid", 32'(pix_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_x", 32'(x), 0);
        chk("arst_y", 32'(y), 0);
        chk("arst_color", 32'(pix_color), 0);
        chk("arst_count", 32'(pix_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("arst_stay_idle", 32'(busy), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
